// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data RAM arbiter.
// Holds the arbiter FSM encoding and the grant selector.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 16;
    localparam int STARVE_MAX_DEF = 4;

    // State names which read return is on ram_q this cycle.
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CPU_RD,
        ARB_DMA_RD
    } arb_state_t;

    typedef enum {
        GNT_NONE,
        GNT_CPU,
        GNT_DMA
    } arb_gnt_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive denied DMA cycles; at_max forces a DMA grant.
// Registered count, combinational at_max; clear has priority over increment.
module arb_starve_counter #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam int            W     = $clog2(MAX + 1);
    localparam logic [W-1:0]  MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between the MEM-stage CPU port (priority) and a DMA port.
// Issue is combinational each cycle; reads return one cycle later; cpu_stall freezes the pipeline.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_valid,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    arb_state_t state_q, state_d;
    arb_gnt_t   gnt;
    logic       cpu_pending;
    logic       forced;
    logic       at_max;
    logic       dma_gnt;
    logic       stall_int;
    logic       we_int;

    arb_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc_i    (dma_valid && !dma_gnt),
        .clr_i    (dma_gnt || !dma_valid),
        .at_max_o (at_max)
    );

    // The load being returned in CPU_RD is still presented by the MEM stage; don't reissue it.
    assign cpu_pending = cpu_req && (state_q != ARB_CPU_RD);
    assign forced      = dma_valid && at_max;

    always_comb begin
        gnt       = GNT_NONE;
        state_d   = ARB_IDLE;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        we_int    = 1'b0;
        stall_int = 1'b0;
        if (forced || (dma_valid && !cpu_pending)) begin
            gnt = GNT_DMA;
        end else if (cpu_pending) begin
            gnt = GNT_CPU;
        end

        case (gnt)
            GNT_DMA: begin
                ram_addr  = dma_addr;
                ram_wdata = dma_wdata;
                we_int    = dma_we;
                stall_int = cpu_pending;
                state_d   = dma_we ? ARB_IDLE : ARB_DMA_RD;
            end
            GNT_CPU: begin
                we_int    = cpu_we;
                stall_int = !cpu_we;
                state_d   = cpu_we ? ARB_IDLE : ARB_CPU_RD;
            end
            default: ;
        endcase
    end

    assign dma_gnt = (gnt == GNT_DMA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests arriving while reset is held must not reach the RAM or either requester.
    assign ram_we     = reset && we_int;
    assign dma_ready  = reset && dma_gnt;
    assign cpu_stall  = reset && stall_int;
    assign cpu_rdata  = (state_q == ARB_CPU_RD) ? ram_q : '0;
    assign dma_rvalid = (state_q == ARB_DMA_RD);
    assign dma_rdata  = (state_q == ARB_DMA_RD) ? ram_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_data_mem_arbiter;

    localparam int SMAX = 4;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, dma_valid, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [15:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata, ram_q;
    logic        cpu_stall, dma_ready, dma_rvalid, ram_we;

    logic [15:0] mem    [0:65535];
    logic [15:0] refmem [0:65535];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, expressed as protocol facts rather than an FSM.
    logic        m_cpu_ret, m_dma_ret;
    logic [15:0] m_cpu_dat, m_dma_dat;
    int          m_denied;
    logic        last_stall, last_ready;

    data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cpu_ret  = 1'b0;
        m_dma_ret  = 1'b0;
        m_denied   = 0;
        last_stall = 1'b0;
        last_ready = 1'b0;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        mem[a]    = d;
        refmem[a] = d;
    endtask

    task automatic step(input logic creq, input logic cwe, input logic [15:0] caddr,
                        input logic [15:0] cwd, input logic dv, input logic dwe,
                        input logic [15:0] dadr, input logic [15:0] dwd);
        logic wants, dwin, exp_stall, exp_we;
        @(posedge clk); #1;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_valid = dv; dma_we = dwe; dma_addr = dadr; dma_wdata = dwd;
        #1;
        wants     = creq && !m_cpu_ret;
        dwin      = dv && ((m_denied >= SMAX) || !wants);
        exp_stall = wants && (dwin || !cwe);
        exp_we    = dwin ? dwe : (wants && cwe);
        chk("cpu_rdata", 32'(cpu_rdata), m_cpu_ret ? 32'(m_cpu_dat) : 32'h0);
        chk("dma_rvalid", 32'(dma_rvalid), 32'(m_dma_ret));
        chk("dma_rdata", 32'(dma_rdata), m_dma_ret ? 32'(m_dma_dat) : 32'h0);
        chk("dma_ready", 32'(dma_ready), 32'(dwin));
        chk("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
        chk("ram_we", 32'(ram_we), 32'(exp_we));
        if (dwin) chk("ram_addr_dma", 32'(ram_addr), 32'(dadr));
        else if (wants) chk("ram_addr_cpu", 32'(ram_addr), 32'(caddr));
        if (exp_we) chk("ram_wdata", 32'(ram_wdata), dwin ? 32'(dwd) : 32'(cwd));
        m_cpu_ret = wants && !dwin && !cwe;
        m_cpu_dat = refmem[caddr];
        m_dma_ret = dwin && !dwe;
        m_dma_dat = refmem[dadr];
        if (dwin && dwe) refmem[dadr] = dwd;
        else if (wants && !dwin && cwe) refmem[caddr] = cwd;
        m_denied   = (dv && !dwin) ? ((m_denied < SMAX) ? m_denied + 1 : SMAX) : 0;
        last_stall = exp_stall;
        last_ready = dwin;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    logic        r_creq, r_cwe, r_dv, r_dwe;
    logic [15:0] r_caddr, r_cwd, r_dadr, r_dwd;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 16'(i * 40503);
            refmem[i] = 16'(i * 40503);
        end
        model_reset();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFFFF; cpu_wdata = 16'hFFFF;
        dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 16'hFFFF; dma_wdata = 16'hFFFF;

        // Reset held with every input high
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_ram_we", 32'(ram_we), 32'h0);
            chk("rst_dma_ready", 32'(dma_ready), 32'h0);
            chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);
            chk("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
        end
        cpu_req = 1'b0; dma_valid = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
        reset = 1'b1;
        idle();

        // CPU load with one stall cycle
        poke(16'h0010, 16'hBEEF);
        step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("t2_stall", 32'(cpu_stall), 32'h1);
        chk("t2_addr", 32'(ram_addr), 32'h0010);
        step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("t2_stall_rd", 32'(cpu_stall), 32'h0);
        chk("t2_rdata", 32'(cpu_rdata), 32'hBEEF);

        // CPU store wins over a pending DMA write
        step(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 1'b1, 16'h0070, 16'h7777);
        chk("t3_we", 32'(ram_we), 32'h1);
        chk("t3_addr", 32'(ram_addr), 32'h0020);
        chk("t3_ready", 32'(dma_ready), 32'h0);
        idle();

        // Starvation forces a DMA read on the fifth cycle
        poke(16'h0030, 16'h5A5A);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 16'(16'h0060 + i), 16'(i), 1'b1, 1'b0, 16'h0030, 16'h0);
        chk("t4_forced_ready", 32'(dma_ready), 32'h1);
        chk("t4_forced_stall", 32'(cpu_stall), 32'h1);
        step(1'b1, 1'b1, 16'h0064, 16'h4, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("t4_rvalid", 32'(dma_rvalid), 32'h1);
        chk("t4_rdata", 32'(dma_rdata), 32'h5A5A);
        // Counter must have cleared: one denied cycle must not force a grant
        step(1'b1, 1'b1, 16'h0065, 16'h5, 1'b1, 1'b1, 16'h0071, 16'h1);
        chk("t4_cnt_cleared", 32'(dma_ready), 32'h0);
        idle();

        // DMA write issues during the CPU load return cycle
        poke(16'h0040, 16'h1111);
        step(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b1, 16'h0050, 16'hAAAA);
        chk("t5_rdata", 32'(cpu_rdata), 32'h1111);
        chk("t5_ready", 32'(dma_ready), 32'h1);
        chk("t5_we", 32'(ram_we), 32'h1);
        chk("t5_addr", 32'(ram_addr), 32'h0050);
        idle();
        step(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("t5_readback", 32'(cpu_rdata), 32'hAAAA);

        // Reset asserted while a DMA read is returning
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0);
        @(posedge clk); #1;
        dma_valid = 1'b0;
        chk("t6_pre_rvalid", 32'(dma_rvalid), 32'h1);
        reset = 1'b0;
        #1;
        chk("t6_rvalid", 32'(dma_rvalid), 32'h0);
        chk("t6_rdata", 32'(dma_rdata), 32'h0);
        chk("t6_we", 32'(ram_we), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        idle();
        chk("t6_post_we", 32'(ram_we), 32'h0);

        // Random traffic honouring pipeline hold and DMA hold rules
        r_creq = 1'b0; r_cwe = 1'b0; r_caddr = '0; r_cwd = '0;
        r_dv = 1'b0; r_dwe = 1'b0; r_dadr = '0; r_dwd = '0;
        for (int n = 0; n < 600; n++) begin
            if (!(last_stall || m_cpu_ret)) begin
                r_creq  = ($urandom_range(0, 3) != 0);
                r_cwe   = $urandom_range(0, 1) == 1;
                r_caddr = 16'($urandom_range(0, 31));
                r_cwd   = 16'($urandom);
            end
            if (!(r_dv && !last_ready)) begin
                r_dv   = $urandom_range(0, 2) != 0;
                r_dwe  = $urandom_range(0, 1) == 1;
                r_dadr = 16'($urandom_range(0, 31));
                r_dwd  = 16'($urandom);
            end
            step(r_creq, r_cwe, r_caddr, r_cwd, r_dv, r_dwe, r_dadr, r_dwd);
        end

        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
